// File: rtl/convolver_pkg.sv
// Shared constants and FSM encoding for the 5x5 convolver and its stream controller.
package convolver_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FRAC_BIT    = 8;
  localparam int KERNEL_SIZE = 5;
  localparam int IMAGE_SIZE  = 28;
  localparam int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that keeps result tags aligned with the datapath latency.
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] entry,
  output logic [WIDTH-1:0] last_stage
);

  logic [WIDTH-1:0] stage [DEPTH];

  // The datapath is free-running, so this advances every cycle whether or not a pixel moved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= entry;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign last_stage = stage[DEPTH-1];

endmodule

// File: rtl/conv_stream_controller.sv
// Frame sequencer for the 5x5 convolver: pixel handshake, raster position tracking,
// and tagging of datapath results whose window lies fully inside the image.
module conv_stream_controller #(
  parameter int KERNEL_SIZE = convolver_pkg::KERNEL_SIZE,
  parameter int IMAGE_SIZE  = convolver_pkg::IMAGE_SIZE,
  parameter int DP_LATENCY  = 3,
  parameter int CNT_W       = $clog2(IMAGE_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             write,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             busy,
  output logic             done
);

  import convolver_pkg::state_t;
  import convolver_pkg::IDLE;
  import convolver_pkg::STREAM;
  import convolver_pkg::DRAIN;
  import convolver_pkg::DONE;

  localparam int DRAIN_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam int TAG_W   = 1 + 2 * CNT_W;

  localparam logic [CNT_W-1:0]   LAST_POS  = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0]   EDGE      = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DP_LATENCY - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   row;
  logic [CNT_W-1:0]   col;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               last_beat;
  logic               win;
  logic [TAG_W-1:0]   tag_in;
  logic [TAG_W-1:0]   tag_out;

  assign write     = in_valid & in_ready;
  assign last_beat = write && (row == LAST_POS) && (col == LAST_POS);
  assign win       = (row >= EDGE) && (col >= EDGE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = STREAM;
      STREAM:  if (last_beat) next_state = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_END) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      STREAM:  begin in_ready = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Position of the pixel being accepted; a full frame wraps both counters back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (write) begin
      if (col == LAST_POS) begin
        col <= '0;
        row <= (row == LAST_POS) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if (state != DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Coordinates ride along only with valid windows so out_row/out_col read zero otherwise.
  always_comb begin
    tag_in = '0;
    if (write && win) begin
      tag_in = {1'b1, row - EDGE, col - EDGE};
    end
  end

  valid_delay_line #(
    .DEPTH(DP_LATENCY),
    .WIDTH(TAG_W)
  ) u_valid_delay_line (
    .clk       (clk),
    .reset     (reset),
    .entry     (tag_in),
    .last_stage(tag_out)
  );

  assign out_valid = tag_out[TAG_W-1];
  assign out_row   = tag_out[2*CNT_W-1:CNT_W];
  assign out_col   = tag_out[CNT_W-1:0];

endmodule

// File: tb/tb_conv_stream_controller.sv
// Scoreboard bench for conv_stream_controller: expected result tags are queued as pixels
// are accepted and popped by an independent monitor whenever out_valid is seen.
module tb_conv_stream_controller;

  localparam int K     = 5;
  localparam int N     = 28;
  localparam int LAT   = 3;
  localparam int CW    = 5;
  localparam int BEATS = N * N;
  localparam int NRES  = (N - K + 1) * (N - K + 1);

  typedef struct {
    int row;
    int col;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          write;
  logic          out_valid;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   results = 0;
  int   done_count = 0;
  int   done_cyc = -1;
  int   done_base = 0;
  int   last_write_cyc = 0;

  conv_stream_controller #(
    .KERNEL_SIZE(K),
    .IMAGE_SIZE (N),
    .DP_LATENCY (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .write    (write),
    .out_valid(out_valid),
    .out_row  (out_row),
    .out_col  (out_col),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_in_ready"}, in_ready, 0);
    checkOutput({name, "_write"}, write, 0);
    checkOutput({name, "_out_valid"}, out_valid, 0);
    checkOutput({name, "_out_row"}, out_row, 0);
    checkOutput({name, "_out_col"}, out_col, 0);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_done"}, done, 0);
  endtask

  // Monitor: every presented result must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_row", out_row, e.row);
        checkOutput("out_col", out_col, e.col);
        checkOutput("out_cycle", cyc, e.cyc);
        results++;
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      checkOutput("missing_out_valid", out_valid, 1);
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic startFrame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    results = 0;
    done_base = done_count;
  endtask

  // Streams one frame; toggle inserts a stall every other cycle, abort_after>0 resets mid-frame.
  task automatic applyStimulus(input bit toggle, input int abort_after,
                               input int start_a, input int start_b);
    int beats;
    int r;
    int c;
    bit phase;
    int d0;
    beats = 0;
    r = 0;
    c = 0;
    phase = 1'b0;
    while (beats < BEATS) begin
      in_valid = toggle ? ~phase : 1'b1;
      phase = ~phase;
      start = (beats == start_a || beats == start_b);
      @(negedge clk);
      checkOutput("in_ready", in_ready, 1);
      checkOutput("write", write, in_valid);
      if (in_valid) begin
        if (r >= K - 1 && c >= K - 1) exp_q.push_back('{r - (K - 1), c - (K - 1), cyc + LAT});
        last_write_cyc = cyc;
        c++;
        if (c == N) begin
          c = 0;
          r++;
        end
        beats++;
        if (beats == abort_after) begin
          @(posedge clk); #1;
          reset = 1'b0;
          in_valid = 1'b0;
          start = 1'b0;
          exp_q.delete();
          d0 = done_count;
          #1;
          checkIdle("async_abort");
          repeat (2) begin
            @(negedge clk);
            checkIdle("abort_hold");
          end
          @(posedge clk); #1;
          reset = 1'b1;
          repeat (LAT + 3) @(negedge clk);
          checkOutput("no_done_after_abort", done_count, d0);
          checkOutput("idle_after_abort_busy", busy, 0);
          return;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finishFrame(input bit start_in_done);
    repeat (LAT) @(posedge clk);
    #1;
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_in_done", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 0);
      checkOutput("idle_busy", busy, 0);
    end
    checkOutput("done_count", done_count - done_base, 1);
    checkOutput("done_cycle", done_cyc, last_write_cyc + LAT + 1);
    checkOutput("result_count", results, NRES);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset_hold");
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkIdle("post_reset");
    end

    $display("[TB] full frame, in_valid held high");
    startFrame();
    applyStimulus(1'b0, 0, -1, -1);
    finishFrame(1'b0);

    $display("[TB] full frame, in_valid toggling");
    startFrame();
    applyStimulus(1'b1, 0, -1, -1);
    finishFrame(1'b0);

    $display("[TB] start pulses while busy and in DONE");
    startFrame();
    applyStimulus(1'b0, 0, 10, 400);
    finishFrame(1'b1);

    $display("[TB] reset mid-frame, then a clean frame");
    startFrame();
    applyStimulus(1'b0, 300, -1, -1);
    startFrame();
    applyStimulus(1'b0, 0, -1, -1);
    finishFrame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
